// File: rtl/sweep_mem_pkg.sv
// Shared types for the sweep memory responder: state encoding and its width.
package sweep_mem_pkg;

  localparam int STATE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT = 6'd0,
    ST_IDLE = 6'd1,
    ST_WR   = 6'd2,
    ST_RD   = 6'd3,
    ST_DONE = 6'd4
  } state_e;

endpackage

// File: rtl/sweep_ram.sv
// Single-port synchronous RAM with registered read, written so it maps onto block RAM.
module sweep_ram #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [DATA_SIZE-1:0] wdat_i,
  output logic [DATA_SIZE-1:0] rdat_o
);

  logic [DATA_SIZE-1:0] mem_q [2**ADDR_SIZE];

  // Write-first is not needed: the responder never reads the word it is writing.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdat_i;
    end
    rdat_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/sweep_mem_responder.sv
// Responder end of the start/rnw/done/ready sweep interface, backed by on-chip RAM.
// Optional macro SWEEP_FAULT_INJECT_EN adds fault_en_i / FAULT_ADDR to flip rdat bit 0
// of one word during read sweeps (stored data is untouched).
//
// state | meaning
// INIT  | counting down the post-reset delay, pulses done on the last count
// IDLE  | waiting for start; latches rnw on accept
// WR    | write sweep, one ready per STRIDE cycles, wdat stored in each ready cycle
// RD    | read sweep, rdat loaded so it is valid in each ready cycle
// DONE  | one-cycle done pulse after the last word
module sweep_mem_responder
  import sweep_mem_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int ADDR_SIZE   = 10,
  parameter int INIT_CYCLES = 100,
  parameter int STRIDE      = 2
`ifdef SWEEP_FAULT_INJECT_EN
  ,
  parameter int FAULT_ADDR  = 0
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 rnw_i,
  input  logic [DATA_SIZE-1:0] wdat_i,
`ifdef SWEEP_FAULT_INJECT_EN
  input  logic                 fault_en_i,
`endif
  output logic                 done_o,
  output logic                 ready_o,
  output logic [DATA_SIZE-1:0] rdat_o,
  output logic [STATE_W-1:0]   state_o
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int PH_W   = $clog2(STRIDE);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STRIDE - 1);

  state_e               state_q, state_d;
  logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic [DATA_SIZE-1:0] rdat_q, rdat_d;
  logic [DATA_SIZE-1:0] ram_rdat;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic                 ram_we;
  logic                 last_word;
  logic                 fault_hit;

  assign last_word = (addr_q == '1);

`ifdef SWEEP_FAULT_INJECT_EN
  assign fault_hit = fault_en_i && (addr_q == ADDR_SIZE'(FAULT_ADDR));
`else
  assign fault_hit = 1'b0;
`endif

  // Writes land on the current word at the close of its ready cycle; reads look one
  // address ahead so the registered RAM output already holds the next word.
  assign ram_we   = (state_q == ST_WR) && ready_q && !rst_i;
  assign ram_addr = (state_q == ST_WR) ? addr_q : addr_d;

  sweep_ram #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk_i (clk_i),
    .we_i  (ram_we),
    .addr_i(ram_addr),
    .wdat_i(wdat_i),
    .rdat_o(ram_rdat)
  );

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    rdat_d     = rdat_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q != '0) begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
        done_d = (init_cnt_q == INIT_W'(1));
        if (init_cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (start_i) begin
          state_d = rnw_i ? ST_RD : ST_WR;
          addr_d  = '0;
          phase_d = '0;
        end
      end
      ST_WR, ST_RD: begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        if (phase_q == PH_LAST) begin
          ready_d = 1'b1;
          if (state_q == ST_RD) begin
            rdat_d = ram_rdat ^ {{(DATA_SIZE-1){1'b0}}, fault_hit};
          end
        end
        if (ready_q) begin
          addr_d = addr_q + 1'b1;
          if (last_word) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and output registers; reset restarts the init delay but leaves RAM alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= INIT_LOAD;
      phase_q    <= '0;
      addr_q     <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      rdat_q     <= rdat_d;
    end
  end

  assign done_o  = done_q;
  assign ready_o = ready_q;
  assign rdat_o  = rdat_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_sweep_mem_responder.sv
// Self-checking bench for sweep_mem_responder: timeline model plus directed literal checks.
module tb_sweep_mem_responder;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int S     = 2;
  localparam int INIT  = 8;
  localparam int WORDS = 16;
  localparam int FADDR = 3;
`ifdef SWEEP_FAULT_INJECT_EN
  localparam bit FLT = 1'b1;
`else
  localparam bit FLT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, rnw, fault_en;
  logic [DW-1:0] wdat;
  logic          done, ready;
  logic [DW-1:0] rdat;
  logic [5:0]    state;

  sweep_mem_responder #(
    .DATA_SIZE  (DW),
    .ADDR_SIZE  (AW),
    .INIT_CYCLES(INIT),
    .STRIDE     (S)
`ifdef SWEEP_FAULT_INJECT_EN
    ,
    .FAULT_ADDR (FADDR)
`endif
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .rnw_i     (rnw),
    .wdat_i    (wdat),
`ifdef SWEEP_FAULT_INJECT_EN
    .fault_en_i(fault_en),
`endif
    .done_o    (done),
    .ready_o   (ready),
    .rdat_o    (rdat),
    .state_o   (state)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: got no DUT response expected one within budget at %0t", name, $time);
  endtask

  // Inputs as seen by the DUT at the most recent rising edge.
  logic          s_rst, s_start, s_rnw, s_fault;
  logic [DW-1:0] s_wdat;
  always @(posedge clk) begin
    s_rst   <= rst;
    s_start <= start;
    s_rnw   <= rnw;
    s_fault <= fault_en;
    s_wdat  <= wdat;
  end

  // Timeline model: edge e, edges since reset release rel, sweep accepted at edge n0.
  logic [DW-1:0] mem [WORDS];
  int  e = 0, rel = 0, n0 = 0, idle_from = 0, d, k;
  bit  act = 1'b0, sw_rnw = 1'b0;
  logic          e_rdy, e_done;
  logic [DW-1:0] e_rdat;
  logic [5:0]    e_state;

  initial begin
    e_rdy = 0; e_done = 0; e_rdat = 0; e_state = 0;
    forever begin
      @(negedge clk);
      e++;
      if (s_rst) begin
        rel = 0; act = 0; idle_from = 0;
        e_rdy = 0; e_done = 0; e_rdat = 0; e_state = 0;
      end else begin
        rel++;
        e_rdy  = 0;
        e_done = 0;
        if (act) begin
          d = e - n0;
          if (!sw_rnw && d > S && (d - 1) % S == 0 && (d - 1) / S <= WORDS)
            mem[(d - 1) / S - 1] = s_wdat;
          if (d % S == 0 && d / S >= 1 && d / S <= WORDS) begin
            e_rdy = 1;
            if (sw_rnw) begin
              k = d / S - 1;
              e_rdat = mem[k] ^ ((FLT && s_fault === 1'b1 && k == FADDR) ? 16'h0001 : 16'h0000);
            end
          end
          if (d <= S * WORDS) e_state = sw_rnw ? 6'd3 : 6'd2;
          else begin
            e_state = 6'd4; e_done = 1; act = 0; idle_from = e + 2;
          end
        end else if (rel >= INIT + 2 && e >= idle_from && s_start) begin
          act = 1; n0 = e; sw_rnw = s_rnw;
          e_state = s_rnw ? 6'd3 : 6'd2;
        end else if (rel < INIT) begin
          e_state = 6'd0;
        end else if (rel == INIT) begin
          e_state = 6'd0; e_done = 1;
        end else begin
          e_state = 6'd1;
        end
      end
      chk("cyc_ready", {31'b0, ready}, {31'b0, e_rdy});
      chk("cyc_done",  {31'b0, done},  {31'b0, e_done});
      chk("cyc_rdat",  {16'b0, rdat},  {16'b0, e_rdat});
      chk("cyc_state", {26'b0, state}, {26'b0, e_state});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    do begin step(); n++; end while (!done && n < 40);
    if (!done) timeout_fail("init_done");
    else chk("init_latency", n, INIT);
  endtask

  // One full sweep; abort_at>0 asserts reset in the ready cycle of that many-th word.
  task automatic sweep(input bit rd, input logic [DW-1:0] base, input bit inc,
                       input int abort_at, input int flt_word, output int ndiff);
    int n, cnt;
    logic [DW-1:0] clean, exp;
    ndiff = 0;
    n = 0;
    start = 0;
    while (state !== 6'd1 && n < 100) begin step(); n++; end
    if (state !== 6'd1) begin timeout_fail("idle_wait"); return; end
    start = 1; rnw = rd;
    step();
    cnt = 0; n = 0;
    while (!done && n < 80) begin
      start = (n == 7);
      step(); n++;
      start = 0;
      if (ready) begin
        clean = inc ? DW'(base + cnt) : base;
        if (!rd) wdat = clean;
        else begin
          exp = (cnt == flt_word) ? (clean ^ 16'h0001) : clean;
          chk("rdat_word", {16'b0, rdat}, {16'b0, exp});
          if (rdat !== clean) ndiff++;
        end
        cnt++;
        if (cnt == abort_at) begin
          rst = 1; step(); rst = 0;
          chk("abort_ready", {31'b0, ready}, 32'd0);
          chk("abort_done",  {31'b0, done},  32'd0);
          chk("abort_rdat",  {16'b0, rdat},  32'd0);
          chk("abort_state", {26'b0, state}, 32'd0);
          return;
        end
      end
    end
    if (!done) begin timeout_fail("sweep_done"); return; end
    chk("sweep_len", n, 2 * WORDS + 1);
    chk("ready_count", cnt, WORDS);
    start = 1;
    step();
    start = 0;
    chk("done_to_idle", {26'b0, state}, 32'd1);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int nd;
    rst = 1; start = 0; rnw = 0; wdat = '0; fault_en = 0;
    repeat (3) step();
    chk("rst_state", {26'b0, state}, 32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rdat",  {16'b0, rdat},  32'd0);

    rst = 0; start = 1;
    wait_init();
    step();
    start = 0;
    chk("init_to_idle", {26'b0, state}, 32'd1);

    sweep(1'b0, 16'h1000, 1'b1, -1, -1, nd);
    sweep(1'b1, 16'h1000, 1'b1, -1, -1, nd);
    chk("read_diffs", nd, 0);
    sweep(1'b1, 16'h1000, 1'b1, 6, -1, nd);
    wait_init();
    sweep(1'b1, 16'h1000, 1'b1, -1, -1, nd);
    chk("retained_diffs", nd, 0);

    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 249) == 0);
      start    = ($urandom_range(0, 5) == 0);
      rnw      = $urandom_range(0, 1);
      wdat     = DW'($urandom);
      fault_en = $urandom_range(0, 1);
      step();
    end
    rst = 0; start = 0; fault_en = 0;

`ifdef SWEEP_FAULT_INJECT_EN
    sweep(1'b0, 16'h0000, 1'b0, -1, -1, nd);
    fault_en = 1;
    sweep(1'b1, 16'h0000, 1'b0, -1, FADDR, nd);
    chk("fault_fails_per_pass", nd, 1);
    fault_en = 0;
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sweep_mem_responder.md
# sweep_mem_responder

On-chip stand-in for the SDRAM controller on the memory tester's `start`/`rnw`/`done`/`ready` sweep interface. It is the responder end of that protocol. After reset it runs a fixed init delay and pulses `done`. Each accepted `start` sweeps the whole block-RAM address space, pulsing `ready` once per word: on writes it stores `wdat`, on reads it presents `rdat`. This lets the tester FSM, random-vector generator and pass/fail counters run on-chip without external SDRAM.

## Interface
- `DATA_SIZE`, 16, word width.
- `ADDR_SIZE`, 10, address bits; one sweep is 2^ADDR_SIZE words.
- `INIT_CYCLES`, 100, cycles from reset release to the init `done` pulse (≥1).
- `STRIDE`, 2, cycles per word (≥2).
- `FAULT_ADDR`, 0, word address corrupted when fault injection is built and enabled.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- `rnw`  in  1  1 = read sweep, 0 = write sweep; sampled together with `start`.
- `wdat`  in  DATA_SIZE  write data, sampled in every `ready` cycle of a write sweep.
- `fault_en`  in  1  present only with `SWEEP_FAULT_INJECT_EN`.
- `done`  out  1  one-cycle pulse: init finished, or sweep finished.
- `ready`  out  1  one-cycle pulse per word.
- `rdat`  out  DATA_SIZE  read data, valid in the `ready` cycles of a read sweep.
- `state`  out  6  current state code, for debug.

## Operation
- States and codes: INIT=0, IDLE=1, WR=2, RD=3, DONE=4. All outputs are registered.
- **INIT**
  - A counter counts cycles after `rst` falls.
  - `done`=1 for exactly one cycle, in the INIT_CYCLES-th cycle after `rst` deasserts; the state is IDLE from the next cycle.
  - `start` is ignored in INIT.
- **IDLE**
  - `start`=1 latches `rnw` and goes to RD or WR.
  - On accept: word address := 0 and phase := 0.
- **WR / RD**
  - `phase` counts 0..STRIDE-1.
  - `ready`=1 only when `phase`=STRIDE-1.
  - WR: the RAM writes `wdat` at the current address in the `ready` cycle.
  - RD: the RAM read address is presented from phase 0; `rdat` is updated so it is valid in the `ready` cycle and holds until the next word.
  - After each `ready`, the address increments.
  - The `ready` at address 2^ADDR_SIZE-1 is the last one; the next state is DONE.
- **DONE**: `done`=1 for one cycle, then IDLE. `start` is ignored in DONE.
- `start` in WR, RD, INIT or DONE is ignored and is not queued.
- `rnw` and `wdat` outside the cycles where they are sampled are don't-care.
- The address wraps naturally at ADDR_SIZE bits; the wrap is never observed externally because the sweep ends there.
- Reset values: `done`=0, `ready`=0, `rdat`=0, `state`=0 (INIT), address=0, phase=0.
- Reset mid-sweep:
  - Aborts immediately with no `done`, and the init delay runs again.
  - RAM contents are retained; words already written stay written.

## Timing
- `start` accepted at edge N → first `ready` in cycle N+STRIDE.
- Consecutive `ready` pulses are exactly STRIDE cycles apart.
- Sweep `done` comes 1 cycle after the last `ready`.
- Sweep length from accept to `done` = STRIDE·2^ADDR_SIZE + 1 cycles.
- Read latency from address to `rdat` is 1 cycle (synchronous RAM); STRIDE ≥ 2 guarantees `rdat` is valid in the `ready` cycle.
- `ready` and `done` are never high in the same cycle.

## Configuration
- `SWEEP_FAULT_INJECT_EN` defined:
  - The `fault_en` port exists.
  - During a read sweep, when `fault_en`=1 and the address = `FAULT_ADDR`, `rdat` bit 0 is inverted in that word's `ready` cycle.
  - Stored data is never altered.
- Not defined: no `fault_en` port, and `rdat` always equals the stored word.

## Structure
- Package `sweep_mem_pkg`: state enum with the fixed 6-bit codes listed above, and the `STATE_W`=6 constant.
- Sub-module `sweep_ram`: single-port synchronous RAM, DATA_SIZE × 2^ADDR_SIZE, with registered read and write-enable, inferable as block RAM.
- The FSM, phase counter, address counter and init counter live in `sweep_mem_responder`.

## Test plan
Common parameters: ADDR_SIZE=4, STRIDE=2, INIT_CYCLES=8.
- **Init:** deassert `rst` → `done` high only in the 8th cycle after; `state` goes 0→1; `ready` stays 0 throughout.
- **Write sweep:** `start`=1 with `rnw`=0, driving `wdat`=0x1000+k for word k → 16 `ready` pulses 2 cycles apart, then `done` 33 cycles after accept.
- **Read sweep after that write:** `start` with `rnw`=1 → `rdat`=0x1000+k in the k-th `ready` cycle for all 16 words, then `done`.
- **Ignored starts:** pulse `start` during INIT, mid-sweep and in DONE → no extra `ready`/`done`, and the sweep length is unchanged.
- **Reset at word 5 of a read:** `ready`/`done`/`rdat` drop to 0 next cycle and init reruns. A following read returns the original data, proving the RAM was retained.
- **With `SWEEP_FAULT_INJECT_EN`, FAULT_ADDR=3, `fault_en`=1, after writing zeros:** a read returns 0x0001 at word 3 and 0x0000 elsewhere. The tester then counts exactly 1 fail per pass.
